m_bpred: RTL and testbench
==========================

# m_bpred

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters, feeding the fetch-stage next-PC mux of the 4-stage pipelined processor. Each cycle it looks up the current fetch PC combinationally and returns hit, predicted-taken and predicted target. It is trained from the execute stage once a valid branch resolves. It replaces the hit-only BTB so that direction is predicted per branch rather than inferred from a tag hit.

## Interface
Parameters:
- IDX_W, 5, index width; the table has 2**IDX_W entries; index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2] (25 bits at default).

Ports:
- w_clk  in  1  clock, rising edge.
- w_rst  in  1  reset; one clock, asynchronous, active-high.
- w_pc  in  32  fetch PC to look up (r_pc).
- w_hit  out  1  entry valid and tag matches w_pc.
- w_tkn  out  1  predict taken; fetch selects w_ppc when high.
- w_ppc  out  32  stored target of indexed entry.
- w_we  in  1  update strobe: a valid branch resolved in execute (P2_v & P2_b).
- w_upc  in  32  PC of the resolved branch.
- w_utkn  in  1  actual branch outcome.
- w_utpc  in  32  actual branch target.
- w_nupd  out  16  count of accepted updates, saturating at 16'hFFFF.

## Operation
- Per-entry state: valid (1), tag (32-IDX_W-2), target (32), ctr (2).
- Lookup is combinational from w_pc:
  - w_hit = valid & (tag == w_pc tag).
  - w_tkn = w_hit & ctr[1].
  - w_ppc = target of the indexed entry regardless of hit.
- Update when w_we=1, on the rising edge:
  - Tag hit and w_utkn=1: ctr = min(ctr+1, 3); target <= w_utpc.
  - Tag hit and w_utkn=0: ctr = max(ctr-1, 0); target unchanged.
  - Tag miss (or invalid) and w_utkn=1: allocate. valid <= 1, tag <= w_upc tag, target <= w_utpc, ctr <= 2'b10. Any previous occupant is silently evicted.
  - Tag miss and w_utkn=0: no table change.
  - w_nupd increments on every w_we=1 cycle, saturating.
- w_upc[1:0] and w_pc[1:0] are ignored.
- Reset clears all valid bits, all ctr to 2'b01, all targets to 0, and w_nupd to 0. Reset asserted mid-operation discards all training immediately, without waiting for a clock edge.

## Timing
- Lookup has zero latency: outputs settle in the same cycle as w_pc.
- An update written at edge N is visible to lookups from cycle N onward, i.e. the cycle after w_we.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update state. There is no write-through bypass.
- Outputs during and immediately after reset: w_hit=0, w_tkn=0, w_ppc=0, w_nupd=0.
- Only one update is accepted per cycle. The caller guarantees w_we is low for squashed instructions.

## Configuration
- BPRED_CTR_EN defined: direction comes from counters as above (w_tkn = w_hit & ctr[1]).
- BPRED_CTR_EN undefined:
  - Counters are not implemented.
  - w_tkn = w_hit.
  - A not-taken update on a tag hit clears valid (invalidate).
  - A taken update behaves as allocate/refresh of tag and target.

## Test plan
- Reset, then lookup w_pc=32'h14 -> w_hit=0, w_tkn=0, w_ppc=0, w_nupd=0.
- Update w_upc=32'h14, w_utkn=1, w_utpc=32'h8, then lookup 32'h14 next cycle -> w_hit=1, w_tkn=1, w_ppc=32'h8, w_nupd=1.
- From that state, apply two not-taken updates to 32'h14:
  - After the first, ctr=1 and w_tkn=0 with BPRED_CTR_EN.
  - Without BPRED_CTR_EN, the first update already gives w_hit=0.
- Aliasing: allocate 32'h14, then a taken update at 32'h94 (same index, different tag) with target 32'h40. Lookup 32'h14 -> w_hit=0; lookup 32'h94 -> w_ppc=32'h40, w_tkn=1.
- Same-cycle: first allocate 32'h14 (taken, target 32'h8) so it hits. Then lookup 32'h14 while updating 32'h14 not-taken, and check both cycles:
  - Update cycle -> w_tkn=1 (old state).
  - Next cycle, ctr=1 -> w_tkn=0.
- Assert w_rst asynchronously between edges after training -> w_hit drops to 0 before the next edge, and w_nupd=0.

Source files
------------

// File: rtl/m_bpred_if.sv
// Fetch/execute-side signal bundle for the m_bpred branch target buffer.
// The master side drives lookups and training, and the slave is the predictor.
interface m_bpred_if;
    logic [31:0] w_pc;
    logic        w_hit;
    logic        w_tkn;
    logic [31:0] w_ppc;
    logic        w_we;
    logic [31:0] w_upc;
    logic        w_utkn;
    logic [31:0] w_utpc;
    logic [15:0] w_nupd;

    modport master (
        output w_pc, w_we, w_upc, w_utkn, w_utpc,
        input  w_hit, w_tkn, w_ppc, w_nupd
    );

    modport slave (
        input  w_pc, w_we, w_upc, w_utkn, w_utpc,
        output w_hit, w_tkn, w_ppc, w_nupd
    );
endinterface

// File: rtl/m_bpred.sv
// Direct-mapped BTB with combinational lookup and execute-stage training.
// Define BPRED_CTR_EN to enable per-entry 2-bit direction counters; otherwise a tag hit predicts taken.
module m_bpred #(
    parameter int IDX_W = 5
) (
    input logic      w_clk,
    input logic      w_rst,
    m_bpred_if.slave bus
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;

    logic             r_valid [N];
    logic [TAG_W-1:0] r_tag   [N];
    logic [31:0]      r_tgt   [N];
`ifdef BPRED_CTR_EN
    logic [1:0]       r_ctr   [N];
`endif
    logic [15:0]      r_nupd;

    logic [IDX_W-1:0] w_lidx;
    logic [TAG_W-1:0] w_ltag;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_lhit;
    logic             w_uhit;
    logic             w_unused;

    assign w_lidx = bus.w_pc[IDX_W+1:2];
    assign w_ltag = bus.w_pc[31:IDX_W+2];
    assign w_uidx = bus.w_upc[IDX_W+1:2];
    assign w_utag = bus.w_upc[31:IDX_W+2];

    // Byte-offset bits never take part in indexing or tag compare.
    assign w_unused = ^{bus.w_pc[1:0], bus.w_upc[1:0]};

    assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    assign bus.w_hit  = w_lhit;
`ifdef BPRED_CTR_EN
    assign bus.w_tkn  = w_lhit & r_ctr[w_lidx][1];
`else
    assign bus.w_tkn  = w_lhit;
`endif
    assign bus.w_ppc  = r_tgt[w_lidx];
    assign bus.w_nupd = r_nupd;

    // Training writes land at the clock edge, so a lookup in the same cycle still sees the old entry.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= 32'h0;
`ifdef BPRED_CTR_EN
                r_ctr[i]   <= 2'b01;
`endif
            end
            r_nupd <= 16'h0;
        end else if (bus.w_we) begin
            if (r_nupd != 16'hFFFF) begin
                r_nupd <= r_nupd + 16'd1;
            end
`ifdef BPRED_CTR_EN
            if (w_uhit) begin
                if (bus.w_utkn) begin
                    if (r_ctr[w_uidx] != 2'b11) begin
                        r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
                    end
                    r_tgt[w_uidx] <= bus.w_utpc;
                end else if (r_ctr[w_uidx] != 2'b00) begin
                    r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
                end
            end else if (bus.w_utkn) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= bus.w_utpc;
                r_ctr[w_uidx]   <= 2'b10;
            end
`else
            // Without counters a not-taken hit simply retires the entry.
            if (bus.w_utkn) begin
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= bus.w_utpc;
            end else if (w_uhit) begin
                r_valid[w_uidx] <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_m_bpred.sv
// Scoreboard bench for m_bpred: a stimulus process queues expected lookups from an abstract table model.
// A negedge monitor compares them, and the bench follows BPRED_CTR_EN the same way the design does.
module tb_m_bpred;
    localparam int IDX_W = 5;
    localparam int N     = 1 << IDX_W;

    typedef struct {
        logic        hit;
        logic        tkn;
        logic [31:0] ppc;
        logic [15:0] nupd;
    } expT;

    logic clk;
    logic rst;
    m_bpred_if bus ();

    m_bpred #(.IDX_W(IDX_W)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .bus   (bus)
    );

    expT         expQ [$];
    int          checks   = 0;
    int          failures = 0;

    bit          mValid [N];
    int unsigned mTag   [N];
    logic [31:0] mTgt   [N];
    int          mCtr   [N];
    int          mUpdates;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idxOf(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = 0;
            mTgt[i]   = 32'h0;
            mCtr[i]   = 1;
        end
        mUpdates = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of lookup (+ optional training) and queue what the lookup must return.
    task automatic applyStimulus(input logic [31:0] pc, input logic we, input logic [31:0] upc,
                                 input logic utkn, input logic [31:0] utpc);
        expT e;
        int  i;
        int  j;
        bit  uh;
        @(posedge clk);
        #1;
        bus.w_pc   = pc;
        bus.w_we   = we;
        bus.w_upc  = upc;
        bus.w_utkn = utkn;
        bus.w_utpc = utpc;

        i     = idxOf(pc);
        e.hit = mValid[i] && (mTag[i] == tagOf(pc));
`ifdef BPRED_CTR_EN
        e.tkn = e.hit && (mCtr[i] >= 2);
`else
        e.tkn = e.hit;
`endif
        e.ppc  = mTgt[i];
        e.nupd = (mUpdates > 65535) ? 16'hFFFF : 16'(mUpdates);
        expQ.push_back(e);

        if (we) begin
            mUpdates++;
            j  = idxOf(upc);
            uh = mValid[j] && (mTag[j] == tagOf(upc));
`ifdef BPRED_CTR_EN
            if (uh && utkn) begin
                mCtr[j] = (mCtr[j] + 1 > 3) ? 3 : mCtr[j] + 1;
                mTgt[j] = utpc;
            end else if (uh) begin
                mCtr[j] = (mCtr[j] - 1 < 0) ? 0 : mCtr[j] - 1;
            end else if (utkn) begin
                mValid[j] = 1'b1;
                mTag[j]   = tagOf(upc);
                mTgt[j]   = utpc;
                mCtr[j]   = 2;
            end
`else
            if (utkn) begin
                mValid[j] = 1'b1;
                mTag[j]   = tagOf(upc);
                mTgt[j]   = utpc;
            end else if (uh) begin
                mValid[j] = 1'b0;
            end
`endif
        end
    endtask

    // Monitor: lookups are combinational, so every queued cycle is compared mid-cycle.
    always @(negedge clk) begin
        expT e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("hit",  {31'h0, bus.w_hit}, {31'h0, e.hit});
            checkOutput("tkn",  {31'h0, bus.w_tkn}, {31'h0, e.tkn});
            checkOutput("ppc",  bus.w_ppc, e.ppc);
            checkOutput("nupd", {16'h0, bus.w_nupd}, {16'h0, e.nupd});
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] upc;
        rst        = 1'b1;
        bus.w_pc   = 32'h0;
        bus.w_we   = 1'b0;
        bus.w_upc  = 32'h0;
        bus.w_utkn = 1'b0;
        bus.w_utpc = 32'h0;
        modelReset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Reset state, allocate, then two not-taken updates (second also a same-cycle lookup).
        applyStimulus(32'h14, 1'b0, 32'h0,  1'b0, 32'h0);
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b1, 32'h8);
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b0, 32'h0);
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b0, 32'h0);
        applyStimulus(32'h14, 1'b0, 32'h0,  1'b0, 32'h0);

        // Aliasing: 0x94 shares the index of 0x14 and evicts it.
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b1, 32'h8);
        applyStimulus(32'h14, 1'b1, 32'h94, 1'b1, 32'h40);
        applyStimulus(32'h14, 1'b0, 32'h0,  1'b0, 32'h0);
        applyStimulus(32'h94, 1'b0, 32'h0,  1'b0, 32'h0);

        // Same-cycle lookup/update returns the old state.
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b1, 32'h8);
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b0, 32'h0);
        applyStimulus(32'h14, 1'b0, 32'h0,  1'b0, 32'h0);

        // Train 0x14 so it hits, then reset between edges.
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b1, 32'h8);
        applyStimulus(32'h14, 1'b1, 32'h14, 1'b1, 32'h8);
        applyStimulus(32'h14, 1'b0, 32'h0,  1'b0, 32'h0);
        @(posedge clk);
        #3;
        checkOutput("preRstHit", {31'h0, bus.w_hit}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstHit",  {31'h0, bus.w_hit}, 32'h0);
        checkOutput("rstTkn",  {31'h0, bus.w_tkn}, 32'h0);
        checkOutput("rstPpc",  bus.w_ppc, 32'h0);
        checkOutput("rstNupd", {16'h0, bus.w_nupd}, 32'h0);
        modelReset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        applyStimulus(32'h14, 1'b0, 32'h0, 1'b0, 32'h0);

        // Random traffic over a few indices and tags so hits, aliasing and saturation all occur.
        for (int k = 0; k < 3000; k++) begin
            pc  = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            upc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) pc[31] = 1'b1;
            if ($urandom_range(0, 1) == 1) upc[31] = 1'b1;
            applyStimulus(pc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), $urandom);
        end
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
